data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 198 +++++++++++++++++++
 tb/tb_data_memory.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Multi-cycle RV32 data memory: IDLE -> ACCESS (ACCESS_LATENCY cycles) -> DONE handshake with byte/half/word loads and stores.
// Optional macro DMEM_MISALIGN_CHECK_EN turns misaligned half/word accesses into access faults instead of force-aligning them.
module data_memory #(
  parameter int DEPTH_WORDS    = 256,
  parameter int ACCESS_LATENCY = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  READ,
  input  logic [2:0]  WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        BUSYWAIT,
  output logic        ERROR
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_count;

  logic [3:0]    r_read;
  logic [2:0]    r_write;
  logic [IW+1:0] r_addr;
  logic [31:0]   r_dataIn;
  logic [31:0]   r_dataOut;
  logic          r_error;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_request;
  logic          w_lastCycle;
  logic          w_loadEn;
  logic          w_storeEn;
  logic          w_loadFunctBad;
  logic          w_storeFunctBad;
  logic          w_loadMisaligned;
  logic          w_storeMisaligned;
  logic          w_illegal;
  logic [IW-1:0] w_index;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_loadData;
  logic [31:0]   w_storeWord;
  logic          w_unusedAddr;

  assign w_request    = READ[3] | WRITE[2];
  assign w_lastCycle  = (r_state == ACCESS) && (r_count == '0);
  assign w_unusedAddr = ^ADDRESS[31:IW+2];

  // Stall whenever a request is pending or in flight; never while held in reset.
  assign BUSYWAIT = RESET && (((r_state == IDLE) && w_request) || (r_state == ACCESS));
  assign DATA_OUT = r_dataOut;
  assign ERROR    = r_error;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_request) w_nextState = ACCESS;
      ACCESS:  if (r_count == '0) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The request is captured once in IDLE so later input changes cannot disturb it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_count  <= '0;
      r_read   <= '0;
      r_write  <= '0;
      r_addr   <= '0;
      r_dataIn <= '0;
    end else if ((r_state == IDLE) && w_request) begin
      r_count  <= CNT_LOAD;
      r_read   <= READ;
      r_write  <= WRITE;
      r_addr   <= ADDRESS[IW+1:0];
      r_dataIn <= DATA_IN;
    end else if ((r_state == ACCESS) && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign w_loadEn        = r_read[3];
  assign w_storeEn       = r_write[2];
  assign w_loadFunctBad  = (r_read[2:0] == 3'b011) || (r_read[2:0] == 3'b110) ||
                           (r_read[2:0] == 3'b111);
  assign w_storeFunctBad = (r_write[1:0] == 2'b11);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_loadMisaligned  = ((r_read[1:0] == 2'b01) && r_addr[0]) ||
                             ((r_read[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
  assign w_storeMisaligned = ((r_write[1:0] == 2'b01) && r_addr[0]) ||
                             ((r_write[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
`else
  assign w_loadMisaligned  = 1'b0;
  assign w_storeMisaligned = 1'b0;
`endif

  assign w_illegal = (w_loadEn && w_storeEn) ||
                     (w_loadEn && (w_loadFunctBad || w_loadMisaligned)) ||
                     (w_storeEn && (w_storeFunctBad || w_storeMisaligned));

  assign w_index = r_addr[IW+1:2];
  assign w_word  = r_mem[w_index];

  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'b00:   w_byte = w_word[7:0];
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

  // funct3[2] selects zero-extension; funct3[1:0] selects the access size.
  always_comb begin
    w_loadData = '0;
    case (r_read[1:0])
      2'b00:   w_loadData = r_read[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_loadData = r_read[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_loadData = w_word;
    endcase
  end

  // Merge the store data into the current word so untouched bytes keep their contents.
  always_comb begin
    w_storeWord = w_word;
    case (r_write[1:0])
      2'b00: begin
        case (r_addr[1:0])
          2'b00:   w_storeWord[7:0]   = r_dataIn[7:0];
          2'b01:   w_storeWord[15:8]  = r_dataIn[7:0];
          2'b10:   w_storeWord[23:16] = r_dataIn[7:0];
          default: w_storeWord[31:24] = r_dataIn[7:0];
        endcase
      end
      2'b01: begin
        if (r_addr[1]) begin
          w_storeWord[31:16] = r_dataIn[15:0];
        end else begin
          w_storeWord[15:0] = r_dataIn[15:0];
        end
      end
      default: w_storeWord = r_dataIn;
    endcase
  end

  // Storage has no reset; an access aborted by reset never reaches its final ACCESS edge.
  always_ff @(posedge CLK) begin
    if (w_lastCycle && w_storeEn && !w_illegal) begin
      r_mem[w_index] <= w_storeWord;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_dataOut <= '0;
      r_error   <= 1'b0;
    end else if (w_lastCycle) begin
      if (w_illegal) begin
        r_dataOut <= '0;
        r_error   <= 1'b1;
      end else begin
        if (w_loadEn) begin
          r_dataOut <= w_loadData;
        end
        r_error <= 1'b0;
      end
    end else begin
      r_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table, reset-abort sequence and randomized traffic vs a byte-array model.
module tb_data_memory;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;
  localparam int BYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        RESET;
  logic [3:0]  READ;
  logic [2:0]  WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] DATA_IN;
  logic [31:0] DATA_OUT;
  logic        BUSYWAIT;
  logic        ERROR;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0]  modelMem [BYTES];
  logic [31:0] modelDout;

  typedef struct {
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] expDout;
    logic        expErr;
    string       name;
  } vec_t;

  vec_t vecs[$];

  data_memory #(
    .DEPTH_WORDS(DEPTH),
    .ACCESS_LATENCY(LAT)
  ) dut (
    .CLK(clk),
    .RESET(RESET),
    .READ(READ),
    .WRITE(WRITE),
    .ADDRESS(ADDRESS),
    .DATA_IN(DATA_IN),
    .DATA_OUT(DATA_OUT),
    .BUSYWAIT(BUSYWAIT),
    .ERROR(ERROR)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic addVec(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                        input logic [31:0] din, input logic [31:0] expDout, input logic expErr,
                        input string name);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.din = din;
    v.expDout = expDout; v.expErr = expErr; v.name = name;
    vecs.push_back(v);
  endtask

  // One full handshake from IDLE; inputs are scrambled right after the latch edge.
  task automatic applyStimulus(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                               input logic [31:0] din, output logic [31:0] dout, output logic err,
                               output int busy, output logic errAfter);
    @(negedge clk);
    READ = rd; WRITE = wr; ADDRESS = addr; DATA_IN = din;
    #1;
    busy = BUSYWAIT ? 1 : 0;
    @(posedge clk);
    #1;
    READ = 4'b0; WRITE = 3'b0; ADDRESS = $urandom; DATA_IN = $urandom;
    for (int k = 0; k < 20 && BUSYWAIT; k++) begin
      busy++;
      @(posedge clk);
      #1;
    end
    dout = DATA_OUT;
    err  = ERROR;
    @(posedge clk);
    #1;
    errAfter = ERROR;
  endtask

  // Reference behaviour: memory as a flat little-endian byte array, values built with plain arithmetic.
  function automatic void modelAccess(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                                      input logic [31:0] din, output logic [31:0] expDout, output logic expErr);
    int     base;
    int     size;
    logic   bad;
    longint v;
    base = int'(addr % 32'(BYTES));
    bad  = (rd[3] && wr[2]) || (rd[3] && (rd[2:0] == 3'd3 || rd[2:0] >= 3'd6)) ||
           (wr[2] && wr[1:0] == 2'd3);
    size = rd[3] ? (1 << rd[1:0]) : (1 << wr[1:0]);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (base % size != 0) bad = 1'b1;
`endif
    if (bad) begin
      modelDout = 32'h0;
      expDout   = 32'h0;
      expErr    = 1'b1;
      return;
    end
    base   = base - (base % size);
    expErr = 1'b0;
    if (rd[3]) begin
      v = 0;
      for (int i = 0; i < size; i++) v += longint'(modelMem[base + i]) << (8 * i);
      if (!rd[2] && size < 4 && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
      modelDout = 32'(v);
    end else begin
      for (int i = 0; i < size; i++) modelMem[base + i] = din[8 * i +: 8];
    end
    expDout = modelDout;
  endfunction

  initial begin
    logic [31:0] dout;
    logic        err;
    logic        errAfter;
    int          busy;
    logic [31:0] expD;
    logic        expE;
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] a;
    logic [31:0] d;
    int          sel;

    RESET = 1'b1; READ = 4'b0; WRITE = 3'b0; ADDRESS = 32'h0; DATA_IN = 32'h0;
    #2;
    RESET = 1'b0;
    READ  = 4'b1010;
    #1;
    checkOutput("reset busywait", {31'b0, BUSYWAIT}, 32'h0);
    checkOutput("reset data_out", DATA_OUT, 32'h0);
    checkOutput("reset error", {31'b0, ERROR}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busywait held", {31'b0, BUSYWAIT}, 32'h0);
    @(negedge clk);
    READ  = 4'b0;
    RESET = 1'b1;

    addVec(4'b0000, 3'b110, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, "SW 0x10");
    addVec(4'b1010, 3'b000, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, "LW 0x10");
    addVec(4'b0000, 3'b100, 32'h13, 32'h00000080, 32'hDEADBEEF, 1'b0, "SB 0x13");
    addVec(4'b1000, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, "LB 0x13");
    addVec(4'b1100, 3'b000, 32'h13, 32'h0,        32'h00000080, 1'b0, "LBU 0x13");
    addVec(4'b1010, 3'b000, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0, "LW after SB");
    addVec(4'b0000, 3'b110, 32'h10, 32'hDEADBEEF, 32'h80ADBEEF, 1'b0, "SW restore");
    addVec(4'b0000, 3'b101, 32'h12, 32'hFFFF1234, 32'h80ADBEEF, 1'b0, "SH 0x12");
    addVec(4'b1101, 3'b000, 32'h12, 32'h0,        32'h00001234, 1'b0, "LHU 0x12");
    addVec(4'b1010, 3'b000, 32'h10, 32'h0,        32'h1234BEEF, 1'b0, "LW after SH");
    addVec(4'b0000, 3'b101, 32'h10, 32'h00008001, 32'h1234BEEF, 1'b0, "SH 0x10");
    addVec(4'b1001, 3'b000, 32'h10, 32'h0,        32'hFFFF8001, 1'b0, "LH 0x10");
    addVec(4'b1010, 3'b000, 32'h10, 32'h0,        32'h12348001, 1'b0, "LW after SH low");
    addVec(4'b1010, 3'b110, 32'h10, 32'h0,        32'h00000000, 1'b1, "read+write");
    addVec(4'b1010, 3'b000, 32'h10, 32'h0,        32'h12348001, 1'b0, "LW after rw fault");
    addVec(4'b1111, 3'b000, 32'h10, 32'h0,        32'h00000000, 1'b1, "read f3 111");
    addVec(4'b1011, 3'b000, 32'h10, 32'h0,        32'h00000000, 1'b1, "read f3 011");
    addVec(4'b0000, 3'b111, 32'h10, 32'h0,        32'h00000000, 1'b1, "write f 11");
    addVec(4'b1010, 3'b000, 32'h410, 32'h0,       32'h12348001, 1'b0, "LW wrap 0x410");
    addVec(4'b1000, 3'b000, 32'h7FFFFC12, 32'h0,  32'h00000034, 1'b0, "LB high bits");
`ifdef DMEM_MISALIGN_CHECK_EN
    addVec(4'b1010, 3'b000, 32'h11, 32'h0,        32'h00000000, 1'b1, "LW 0x11 fault");
    addVec(4'b1101, 3'b000, 32'h13, 32'h0,        32'h00000000, 1'b1, "LHU 0x13 fault");
    addVec(4'b0000, 3'b110, 32'h11, 32'hCAFEF00D, 32'h00000000, 1'b1, "SW 0x11 fault");
    addVec(4'b1010, 3'b000, 32'h10, 32'h0,        32'h12348001, 1'b0, "LW after SW fault");
`else
    addVec(4'b1010, 3'b000, 32'h11, 32'h0,        32'h12348001, 1'b0, "LW 0x11 aligned");
    addVec(4'b1101, 3'b000, 32'h13, 32'h0,        32'h00001234, 1'b0, "LHU 0x13 aligned");
    addVec(4'b0000, 3'b110, 32'h11, 32'hCAFEF00D, 32'h00001234, 1'b0, "SW 0x11 aligned");
    addVec(4'b1010, 3'b000, 32'h10, 32'h0,        32'hCAFEF00D, 1'b0, "LW after SW 0x11");
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, dout, err, busy, errAfter);
      checkOutput({vecs[i].name, " data"}, dout, vecs[i].expDout);
      checkOutput({vecs[i].name, " error"}, {31'b0, err}, {31'b0, vecs[i].expErr});
      checkOutput({vecs[i].name, " busy cycles"}, 32'(busy), 32'(LAT + 1));
      checkOutput({vecs[i].name, " error after done"}, {31'b0, errAfter}, 32'h0);
    end

    // Reset in the second ACCESS cycle of a store must abort it.
    applyStimulus(4'b0000, 3'b110, 32'h20, 32'h0BADF00D, dout, err, busy, errAfter);
    @(negedge clk);
    WRITE = 3'b110; ADDRESS = 32'h20; DATA_IN = 32'h55555555;
    @(posedge clk);
    #1;
    WRITE = 3'b000;
    @(posedge clk);
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("abort busywait", {31'b0, BUSYWAIT}, 32'h0);
    checkOutput("abort data_out", DATA_OUT, 32'h0);
    checkOutput("abort error", {31'b0, ERROR}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    RESET = 1'b1;
    applyStimulus(4'b1010, 3'b000, 32'h20, 32'h0, dout, err, busy, errAfter);
    checkOutput("LW after abort", dout, 32'h0BADF00D);
    checkOutput("LW after abort error", {31'b0, err}, 32'h0);

    modelDout = 32'h0BADF00D;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      modelAccess(4'b0000, 3'b110, 32'(w * 4), d, expD, expE);
      applyStimulus(4'b0000, 3'b110, 32'(w * 4), d, dout, err, busy, errAfter);
    end

    for (int n = 0; n < 200; n++) begin
      sel = int'($urandom_range(0, 9));
      a   = $urandom & 32'hFFFFFC3F;
      d   = $urandom;
      rd  = 4'b0;
      wr  = 3'b0;
      if (sel <= 4) begin
        rd = {1'b1, 3'($urandom_range(0, 7))};
      end else if (sel <= 8) begin
        wr = {1'b1, 2'($urandom_range(0, 3))};
      end else begin
        rd = 4'b1010;
        wr = 3'b110;
      end
      modelAccess(rd, wr, a, d, expD, expE);
      applyStimulus(rd, wr, a, d, dout, err, busy, errAfter);
      checkOutput("random data", dout, expD);
      checkOutput("random error", {31'b0, err}, {31'b0, expE});
      checkOutput("random busy cycles", 32'(busy), 32'(LAT + 1));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
